// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr: per-output round-robin switch allocator with wormhole locking, registered crossbar control
module switch_alloc_rr #(
  parameter int NUM_PORT = 5,
  parameter bit LOCK_EN  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PORT*NUM_PORT-1:0] req_vector,
  input  logic [NUM_PORT-1:0]          tail_vector,
  input  logic [NUM_PORT-1:0]          out_avail,
  output logic [NUM_PORT*NUM_PORT-1:0] alloc_vector,
  output logic [NUM_PORT-1:0]          grant
);
  localparam int PW = NUM_PORT > 1 ? $clog2(NUM_PORT) : 1;
  typedef enum logic {IDLE, LOCKED} st_e;
  st_e                         st_q  [NUM_PORT];
  st_e                         st_d  [NUM_PORT];
  logic [PW-1:0]               own_q [NUM_PORT];
  logic [PW-1:0]               own_d [NUM_PORT];
  logic [PW-1:0]               ptr_q [NUM_PORT];
  logic [PW-1:0]               ptr_d [NUM_PORT];
  logic [PW-1:0]               win   [NUM_PORT];
  logic [NUM_PORT-1:0]         col   [NUM_PORT];
  logic [NUM_PORT-1:0]         hit;
  logic [NUM_PORT*NUM_PORT-1:0] alloc_d, alloc_q;
  logic [NUM_PORT-1:0]         grant_d, grant_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q <= '0;
      grant_q <= '0;
      for (int k = 0; k < NUM_PORT; k++) begin
        st_q[k]  <= IDLE;
        own_q[k] <= '0;
        ptr_q[k] <= '0;
      end
    end else begin
      alloc_q <= alloc_d;
      grant_q <= grant_d;
      st_q    <= st_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
    end
  end
  // col[k][j]: input j requests output k, after keeping only the lowest set bit of each input slice
  always_comb begin
    logic [NUM_PORT-1:0] slice, low;
    slice = '0;
    low   = '0;
    for (int k = 0; k < NUM_PORT; k++) col[k] = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      slice = req_vector[j*NUM_PORT+:NUM_PORT];
      low   = slice & (~slice + NUM_PORT'(1));
      for (int k = 0; k < NUM_PORT; k++) col[k][j] = low[k];
    end
  end
  always_comb begin
    int idx;
    idx = 0;
    for (int k = 0; k < NUM_PORT; k++) begin
      st_d[k]  = st_q[k];
      own_d[k] = own_q[k];
      ptr_d[k] = ptr_q[k];
      win[k]   = own_q[k];
      hit[k]   = 1'b0;
      if (st_q[k] == LOCKED) begin
        hit[k] = out_avail[k] && col[k][own_q[k]];
        st_d[k] = (hit[k] && tail_vector[own_q[k]]) ? IDLE : LOCKED;
      end else if (out_avail[k]) begin
        // scan backwards so the last match is the first requester at or after the pointer
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
          idx = int'(ptr_q[k]) + i;
          idx = idx >= NUM_PORT ? idx - NUM_PORT : idx;
          if (col[k][idx]) begin
            hit[k] = 1'b1;
            win[k] = PW'(idx);
          end
        end
        if (hit[k]) begin
          ptr_d[k] = win[k] == PW'(NUM_PORT - 1) ? '0 : win[k] + PW'(1);
          if (LOCK_EN && !tail_vector[win[k]]) begin
            st_d[k]  = LOCKED;
            own_d[k] = win[k];
          end
        end
      end
    end
  end
  always_comb begin
    alloc_d = '0;
    grant_d = '0;
    for (int j = 0; j < NUM_PORT; j++) begin
      for (int k = 0; k < NUM_PORT; k++) alloc_d[j*NUM_PORT+k] = hit[k] && win[k] == PW'(j);
      grant_d[j] = |alloc_d[j*NUM_PORT+:NUM_PORT];
    end
  end
  assign alloc_vector = alloc_q;
  assign grant        = grant_q;
endmodule

// File: tb/tb_switch_alloc_rr.sv
// tb_switch_alloc_rr: directed scoreboard bench for the round-robin switch allocator
module tb_switch_alloc_rr;
  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] req_vector;
  logic [4:0]  tail_vector;
  logic [4:0]  out_avail;
  logic [24:0] alloc_vector;
  logic [4:0]  grant;
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic [24:0] a;
    logic [4:0]  g;
    string       tag;
  } exp_t;
  exp_t sb[$];
  switch_alloc_rr #(.NUM_PORT(5), .LOCK_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_vector(req_vector), .tail_vector(tail_vector),
    .out_avail(out_avail), .alloc_vector(alloc_vector), .grant(grant)
  );
  always #5 clk = ~clk;
  function automatic logic [24:0] rq(input int j, input int k);
    logic [24:0] v;
    v = '0;
    v[j*5+k] = 1'b1;
    return v;
  endfunction
  task automatic step(input string tag, input logic rst_v, input logic [24:0] r, input logic [4:0] t,
                      input logic [4:0] av, input logic [24:0] ea, input logic [4:0] eg);
    exp_t e;
    reset = rst_v;
    req_vector = r;
    tail_vector = t;
    out_avail = av;
    sb.push_back('{ea, eg, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    vectors++;
    assert (alloc_vector === e.a) else begin
      miscompares++;
      $error("FAIL %s alloc_vector got %h expected %h", e.tag, alloc_vector, e.a);
    end
    vectors++;
    assert (grant === e.g) else begin
      miscompares++;
      $error("FAIL %s grant got %b expected %b", e.tag, grant, e.g);
    end
  endtask
  initial begin
    logic [24:0] v;
    logic [24:0] r13;
    int w;
    reset = 1'b1;
    req_vector = '0;
    tail_vector = '0;
    out_avail = '0;
    step("reset", 1'b1, '0, '0, '0, '0, '0);
    v = '0;
    for (int j = 0; j < 5; j++) v |= rq(j, (j + 1) % 5);
    step("perm", 1'b0, v, '1, '1, v, 5'b11111);
    step("perm_drop", 1'b0, '0, '1, '1, '0, '0);
    step("reset2", 1'b1, v, '1, '1, '0, '0);
    for (int c = 0; c < 6; c++) begin
      w = (c % 3) * 2;
      step("rr_out3", 1'b0, rq(0, 3) | rq(2, 3) | rq(4, 3), '1, '1, rq(w, 3), 5'(1 << w));
    end
    step("reset3", 1'b1, '0, '0, '0, '0, '0);
    r13 = rq(1, 2) | rq(3, 2);
    step("lock_head", 1'b0, r13, 5'b01000, '1, rq(1, 2), 5'b00010);
    step("lock_bubble", 1'b0, r13, 5'b01000, 5'b11011, '0, '0);
    for (int c = 0; c < 3; c++) step("lock_body", 1'b0, r13, 5'b01000, '1, rq(1, 2), 5'b00010);
    step("lock_tail", 1'b0, r13, 5'b01010, '1, rq(1, 2), 5'b00010);
    step("after_tail", 1'b0, rq(3, 2), 5'b01000, '1, rq(3, 2), 5'b01000);
    step("reset4", 1'b1, '0, '0, '0, '0, '0);
    for (int c = 0; c < 3; c++) step("avail_off", 1'b0, rq(4, 0), '1, 5'b11110, '0, '0);
    step("avail_on", 1'b0, rq(4, 0), '1, '1, rq(4, 0), 5'b10000);
    step("reset5", 1'b1, '0, '0, '0, '0, '0);
    v = '0;
    v[14:10] = 5'b10110;
    step("multihot", 1'b0, v, '1, '1, rq(2, 1), 5'b00100);
    step("reset6", 1'b1, '0, '0, '0, '0, '0);
    step("lk6_head", 1'b0, rq(1, 2), 5'b00000, '1, rq(1, 2), 5'b00010);
    step("lk6_reset", 1'b1, r13, 5'b00000, '1, '0, '0);
    step("lk6_after", 1'b0, rq(3, 2), '1, '1, rq(3, 2), 5'b01000);
    step("lk6_rr", 1'b0, r13, '1, '1, rq(1, 2), 5'b00010);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
